// File: rtl/ika2151_acc_pkg.sv
// Shared constants and types for the ika2151 output accumulator.
// Carrier masks are indexed by algorithm; bit n of an entry marks op n (0=M1..3=C2) as a carrier.
package ika2151_acc_pkg;

  localparam int ACC_W_DEF = 19;

  localparam logic [7:0][3:0] CARRIER_MASK = {
    4'b1111,  // alg 7
    4'b1110,  // alg 6
    4'b1110,  // alg 5
    4'b1100,  // alg 4
    4'b1000,  // alg 3
    4'b1000,  // alg 2
    4'b1000,  // alg 1
    4'b1000   // alg 0
  };

  localparam logic [4:0] SLOT_FIRST      = 5'd0;
  localparam logic [4:0] SLOT_NOISE      = 5'd31;
  localparam logic [4:0] SLOT_L_SH_START = 5'd3;
  localparam logic [4:0] SLOT_L_SH_END   = 5'd15;
  localparam logic [4:0] SLOT_R_SH_START = 5'd19;

  typedef struct packed {
    logic [2:0] expo;
    logic [9:0] mant;
  } flt_t;

endpackage

// File: rtl/ika2151_acc_fltconv.sv
// Saturates a frame sum to 16 bits and registers its 10-bit mantissa / 3-bit exponent form.
// IKA2151_ACC_PARALLEL_OUT_EN additionally exposes the registered saturated value.
module ika2151_acc_fltconv
  import ika2151_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_latch,
  input  logic signed [ACC_W-1:0] i_sum,
  output flt_t                    o_flt
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
  ,
  output logic signed [15:0]      o_lat
`endif
);

  localparam logic signed [ACC_W-1:0] SAT_MAX = 32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -32768;

  logic signed [15:0] sat_v;
  logic [2:0]         lead_n;
  logic [2:0]         e_val;
  flt_t               flt_d, flt_q;

  always_comb begin
    if (i_sum > SAT_MAX) begin
      sat_v = 16'sh7fff;
    end else if (i_sum < SAT_MIN) begin
      sat_v = -16'sh8000;
    end else begin
      sat_v = i_sum[15:0];
    end

    // Highest bit of [14:9] that differs from the sign ends the run of sign copies.
    lead_n = 3'd6;
    for (int i = 0; i < 6; i++) begin
      if (sat_v[9+i] != sat_v[15]) lead_n = 3'(5 - i);
    end
    e_val = 3'd7 - lead_n;

    flt_d = flt_q;
    if (i_latch) begin
      flt_d.expo = e_val;
      flt_d.mant = 10'(sat_v >> (e_val - 3'd1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flt_q <= '0;
    else     flt_q <= flt_d;
  end

  assign o_flt = flt_q;

`ifdef IKA2151_ACC_PARALLEL_OUT_EN
  logic signed [15:0] lat_d, lat_q;

  always_comb lat_d = i_latch ? sat_v : lat_q;

  always_ff @(posedge clk) begin
    if (rst) lat_q <= '0;
    else     lat_q <= lat_d;
  end

  assign o_lat = lat_q;
`endif

endmodule

// File: rtl/ika2151_acc.sv
// Stereo output accumulator: sums carrier outputs per 32-slot frame and shifts float words to the DAC.
// IKA2151_ACC_PARALLEL_OUT_EN adds o_EMU_L/o_EMU_R/o_EMU_VALID parallel outputs.
module ika2151_acc
  import ika2151_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               i_EMUCLK,
  input  logic               i_MRST,
  input  logic               i_phi1_NCEN_n,
  input  logic [4:0]         i_SLOT,
  input  logic [2:0]         i_ALG,
  input  logic [1:0]         i_RL,
  input  logic               i_NE,
  input  logic signed [13:0] i_OP_OUT,
  input  logic signed [13:0] i_ACC_NOISE,
  output logic               o_SO,
  output logic               o_SH1,
  output logic               o_SH2
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
  ,
  output logic [15:0]        o_EMU_L,
  output logic [15:0]        o_EMU_R,
  output logic               o_EMU_VALID
`endif
);

  logic                    en;
  logic signed [13:0]      sample;
  logic signed [ACC_W-1:0] sample_ext, contrib_l, contrib_r, sum_l, sum_r;
  logic signed [ACC_W-1:0] acc_l_d, acc_l_q, acc_r_d, acc_r_q;
  logic                    carrier, latch;
  logic                    frame_valid_d, frame_valid_q;
  logic                    so_d, so_q, sh1_d, sh1_q, sh2_d, sh2_q;
  logic [12:0]             word_l, word_r;
  logic [3:0]              idx_l, idx_r;
  flt_t                    flt_l, flt_r;

  always_comb begin
    en         = ~i_phi1_NCEN_n;
    sample     = (i_SLOT == SLOT_NOISE && i_NE) ? i_ACC_NOISE : i_OP_OUT;
    sample_ext = {{(ACC_W-14){sample[13]}}, sample};
    carrier    = CARRIER_MASK[i_ALG][i_SLOT[4:3]];
    contrib_l  = (carrier && i_RL[0]) ? sample_ext : '0;
    contrib_r  = (carrier && i_RL[1]) ? sample_ext : '0;
    sum_l      = ((i_SLOT == SLOT_FIRST) ? '0 : acc_l_q) + contrib_l;
    sum_r      = ((i_SLOT == SLOT_FIRST) ? '0 : acc_r_q) + contrib_r;
    acc_l_d    = en ? sum_l : acc_l_q;
    acc_r_d    = en ? sum_r : acc_r_q;

    // A frame only counts once slot 0 has been seen since reset, so a partial frame is dropped.
    frame_valid_d = frame_valid_q | (en && i_SLOT == SLOT_FIRST);
    latch         = en && (i_SLOT == SLOT_NOISE) && frame_valid_q;

    word_l = flt_l;
    word_r = flt_r;
    idx_l  = 4'(i_SLOT - SLOT_L_SH_START);
    idx_r  = 4'(i_SLOT - SLOT_R_SH_START);

    so_d  = so_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    if (en) begin
      so_d  = 1'b0;
      sh1_d = 1'b0;
      sh2_d = 1'b0;
      if (i_SLOT >= SLOT_L_SH_START && i_SLOT <= SLOT_L_SH_END) begin
        sh1_d = 1'b1;
        so_d  = word_l[idx_l];
      end else if (i_SLOT >= SLOT_R_SH_START) begin
        sh2_d = 1'b1;
        so_d  = word_r[idx_r];
      end
    end
  end

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) begin
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      frame_valid_q <= 1'b0;
      so_q          <= 1'b0;
      sh1_q         <= 1'b0;
      sh2_q         <= 1'b0;
    end else begin
      acc_l_q       <= acc_l_d;
      acc_r_q       <= acc_r_d;
      frame_valid_q <= frame_valid_d;
      so_q          <= so_d;
      sh1_q         <= sh1_d;
      sh2_q         <= sh2_d;
    end
  end

  assign o_SO  = so_q;
  assign o_SH1 = sh1_q;
  assign o_SH2 = sh2_q;

`ifdef IKA2151_ACC_PARALLEL_OUT_EN
  logic signed [15:0] lat_l, lat_r;
  logic               emu_valid_d, emu_valid_q;

  ika2151_acc_fltconv #(.ACC_W(ACC_W)) u_conv_l (
    .clk(i_EMUCLK), .rst(i_MRST), .i_latch(latch), .i_sum(sum_l), .o_flt(flt_l), .o_lat(lat_l)
  );
  ika2151_acc_fltconv #(.ACC_W(ACC_W)) u_conv_r (
    .clk(i_EMUCLK), .rst(i_MRST), .i_latch(latch), .i_sum(sum_r), .o_flt(flt_r), .o_lat(lat_r)
  );

  always_comb emu_valid_d = en ? latch : emu_valid_q;

  always_ff @(posedge i_EMUCLK) begin
    if (i_MRST) emu_valid_q <= 1'b0;
    else        emu_valid_q <= emu_valid_d;
  end

  assign o_EMU_L     = lat_l;
  assign o_EMU_R     = lat_r;
  assign o_EMU_VALID = emu_valid_q;
`else
  ika2151_acc_fltconv #(.ACC_W(ACC_W)) u_conv_l (
    .clk(i_EMUCLK), .rst(i_MRST), .i_latch(latch), .i_sum(sum_l), .o_flt(flt_l)
  );
  ika2151_acc_fltconv #(.ACC_W(ACC_W)) u_conv_r (
    .clk(i_EMUCLK), .rst(i_MRST), .i_latch(latch), .i_sum(sum_r), .o_flt(flt_r)
  );
`endif

endmodule

// File: tb/tb_ika2151_acc.sv
// Directed bench for ika2151_acc: a per-slot scoreboard of serial outputs built from a frame-sum model.
// Build with IKA2151_ACC_PARALLEL_OUT_EN to also check the parallel outputs.
module tb_ika2151_acc;

  logic              clk = 1'b0;
  logic              mrst = 1'b1;
  logic              ncen_n = 1'b1;
  logic [4:0]        slot = '0;
  logic [2:0]        alg = '0;
  logic [1:0]        rl = '0;
  logic              ne = 1'b0;
  logic signed [13:0] op_out = '0;
  logic signed [13:0] noise = '0;
  logic              so, sh1, sh2;
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
  logic [15:0]       emu_l, emu_r;
  logic              emu_valid;
`endif

  always #5 clk = ~clk;

  ika2151_acc dut (
    .i_EMUCLK(clk), .i_MRST(mrst), .i_phi1_NCEN_n(ncen_n), .i_SLOT(slot), .i_ALG(alg),
    .i_RL(rl), .i_NE(ne), .i_OP_OUT(op_out), .i_ACC_NOISE(noise),
    .o_SO(so), .o_SH1(sh1), .o_SH2(sh2)
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
    , .o_EMU_L(emu_l), .o_EMU_R(emu_r), .o_EMU_VALID(emu_valid)
`endif
  );

  typedef struct packed {logic so; logic sh1; logic sh2;} obs_t;

  obs_t sb[$];
  obs_t last_exp = '0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   acc_l = 0, acc_r = 0, lat_l = 0, lat_r = 0;
  bit   mvalid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit is_carrier(input int a, input int op);
    case (a)
      0, 1, 2, 3: return op == 3;
      4:          return op >= 2;
      5, 6:       return op >= 1;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Word bits [9:0] mantissa, [12:10] exponent; serialised from bit 0 upward.
  function automatic logic [12:0] to_float(input int v);
    int n, e;
    logic [12:0] w;
    n = 0;
    for (int b = 14; b >= 9; b--) begin
      if (((v >>> b) & 1) != ((v >>> 15) & 1)) break;
      n++;
    end
    e = 7 - n;
    w[12:10] = 3'(e);
    w[9:0]   = 10'((v >>> (e - 1)) & 1023);
    return w;
  endfunction

  function automatic obs_t slot_exp(input int s, input logic [12:0] wl, input logic [12:0] wr);
    obs_t o;
    o = '0;
    if (s >= 3 && s <= 15) begin
      o.sh1 = 1'b1;
      o.so  = wl[s-3];
    end else if (s >= 19) begin
      o.sh2 = 1'b1;
      o.so  = wr[s-19];
    end
    return o;
  endfunction

  task automatic push_frame(input int from, input logic [12:0] wl, input logic [12:0] wr);
    for (int s = from; s < 32; s++) sb.push_back(slot_exp(s, wl, wr));
  endtask

  task automatic tick(input int s, input int op, input int a, input logic [1:0] r,
                      input bit n_en, input int nz, input bit stall);
    obs_t e;
    int smp, cl, cr;
    bit car;
    if (stall) begin
      ncen_n = 1'b1;
      slot   = 5'($urandom);
      op_out = 14'($urandom);
      @(posedge clk); #1;
      chk("hold_so", 32'(so), 32'(last_exp.so));
      chk("hold_sh1", 32'(sh1), 32'(last_exp.sh1));
      chk("hold_sh2", 32'(sh2), 32'(last_exp.sh2));
    end
    slot = 5'(s); op_out = 14'(op); alg = 3'(a); rl = r; ne = n_en; noise = 14'(nz);
    ncen_n = 1'b0;
    @(posedge clk); #1;
    chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    chk($sformatf("so_s%0d", s), 32'(so), 32'(e.so));
    chk($sformatf("sh1_s%0d", s), 32'(sh1), 32'(e.sh1));
    chk($sformatf("sh2_s%0d", s), 32'(sh2), 32'(e.sh2));
    last_exp = e;

    smp = (s == 31 && n_en) ? nz : op;
    car = is_carrier(a, s / 8);
    cl  = (car && r[0]) ? smp : 0;
    cr  = (car && r[1]) ? smp : 0;
    if (s == 0) begin
      acc_l = cl; acc_r = cr; mvalid = 1'b1;
    end else begin
      acc_l += cl; acc_r += cr;
    end
    if (s == 31) begin
      if (mvalid) begin
        lat_l = sat(acc_l); lat_r = sat(acc_r);
        push_frame(0, to_float(lat_l), to_float(lat_r));
      end else begin
        push_frame(0, '0, '0);
      end
    end
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
    chk("emu_valid", 32'(emu_valid), 32'(s == 31 && mvalid));
    if (s == 31 && mvalid) begin
      chk("emu_l", 32'(emu_l), 32'(16'(lat_l)));
      chk("emu_r", 32'(emu_r), 32'(16'(lat_r)));
    end
`endif
  endtask

  task automatic run_frame(input int a, input logic [15:0] rl_all, input int op, input int op31,
                           input bit n_en, input int nz, input bit stall, input int from, input int upto);
    for (int s = from; s <= upto; s++)
      tick(s, (s == 31) ? op31 : op, a, rl_all[(s % 8) * 2 +: 2], n_en, nz, stall);
  endtask

  task automatic do_reset(input int at_slot, input int cycles, input int next_slot);
    mrst = 1'b1; ncen_n = 1'b0; slot = 5'(at_slot); op_out = 14'sd777;
    repeat (cycles) @(posedge clk);
    #1;
    chk("rst_so", 32'(so), 32'd0);
    chk("rst_sh1", 32'(sh1), 32'd0);
    chk("rst_sh2", 32'(sh2), 32'd0);
`ifdef IKA2151_ACC_PARALLEL_OUT_EN
    chk("rst_emu_l", 32'(emu_l), 32'd0);
    chk("rst_emu_r", 32'(emu_r), 32'd0);
    chk("rst_emu_valid", 32'(emu_valid), 32'd0);
`endif
    mrst = 1'b0;
    sb.delete();
    mvalid   = 1'b0;
    last_exp = '0;
    push_frame(next_slot, '0, '0);
  endtask

  initial begin
    do_reset(0, 3, 0);
    // ALG7 L-only 100s with stalls: L=3200
    run_frame(7, 16'h5555, 100, 100, 1'b0, 0, 1'b1, 0, 31);
    // ALG0 both sides 8191: saturates to 32767
    run_frame(0, 16'hffff, 8191, 8191, 1'b0, 0, 1'b0, 0, 31);
    // noise replaces op on slot 31, only ch7 routed
    run_frame(0, 16'hc000, 1234, 5000, 1'b1, -8192, 1'b0, 0, 31);
    // all -1 on ALG7: -32
    run_frame(7, 16'hffff, -1, -1, 1'b0, 0, 1'b1, 0, 31);
    // ALG4 and ALG5 right-only 50s: 800 and 1200
    run_frame(4, 16'haaaa, 50, 50, 1'b0, 0, 1'b0, 0, 31);
    run_frame(5, 16'haaaa, 50, 50, 1'b0, 0, 1'b0, 0, 31);
    // reset mid-frame at slot 12, then partial frame is discarded
    run_frame(7, 16'h5555, 100, 100, 1'b0, 0, 1'b0, 0, 11);
    do_reset(12, 1, 13);
    run_frame(0, 16'hffff, 8191, 8191, 1'b0, 0, 1'b0, 13, 31);
    run_frame(7, 16'h5555, 100, 100, 1'b0, 0, 1'b0, 0, 31);
    run_frame(0, 16'h0000, 0, 0, 1'b0, 0, 1'b0, 0, 31);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
